// File: rtl/mux_arb_pkg.sv
// Shared types for the round-robin mux arbiter: FSM states, requester IDs
// and the {valid, id} tag carried alongside each beat through the mux.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } arb_state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef struct packed {
    logic vld;
    logic id;
  } arb_tag_t;

  // Serving state that corresponds to a requester ID.
  function automatic arb_state_t serve_state(input logic id);
    return (id == ID_B) ? SERVE_B : SERVE_A;
  endfunction

endpackage

// File: rtl/mux_arb_tag_pipe.sv
// Fixed-depth shift register of arb_tag_t. It runs in lock-step with the
// external registered mux, so the tag leaving the last stage describes the
// word currently on the mux output. It never stalls; a synchronous reset
// drops every in-flight tag.
module mux_arb_tag_pipe
  import mux_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     i_clk,
  input  logic     i_srst,
  input  arb_tag_t i_tag,
  output arb_tag_t o_tag
);

  arb_tag_t [DEPTH-1:0] r_stage;
  arb_tag_t [DEPTH-1:0] w_stage_d;

  // Stage 0 loads the new tag; each later stage takes its predecessor.
  assign w_stage_d[0] = i_tag;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_link
      assign w_stage_d[gi] = r_stage[gi-1];
    end
  endgenerate

  // Advance the whole pipe every cycle; reset clears all stages.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_stage <= '0;
    end else begin
      r_stage <= w_stage_d;
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter in front of a registered 2:1 mux datapath.
// Two requesters (A, B) hand over beats with valid/ready. At most one beat is
// accepted per cycle and steered through the mux. A tag pipe matching the mux
// latency returns each mux output with a valid flag and the requester ID.
// Optional feature: define MUX_ARB_STATS_EN to add saturating per-requester
// accepted-beat counters on o_cnt_a / o_cnt_b.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW          = 32,
  parameter int MAX_BURST   = 4,
  parameter int MUX_LATENCY = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_a_valid,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_ready,
  input  logic          i_b_valid,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_ready,
  output logic [DW-1:0] o_mux_a,
  output logic [DW-1:0] o_mux_b,
  output logic          o_mux_sel,
  output logic          o_mux_in_val,
  input  logic [DW-1:0] i_mux_out,
  output logic          o_out_valid,
  output logic          o_out_id,
  output logic [DW-1:0] o_out_data
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [15:0]   o_cnt_a,
  output logic [15:0]   o_cnt_b
`endif
);

  // Burst counter must hold 0..MAX_BURST-1 and still work for MAX_BURST=1.
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  arb_state_t    r_state;
  logic          r_last;
  logic [CW-1:0] r_burst_cnt;

  logic     w_serving;
  logic     w_cur_id;
  logic     w_cur_valid;
  logic     w_oth_valid;
  logic     w_acc;
  logic     w_burst_end;
  arb_tag_t w_tag_in;
  arb_tag_t w_tag_out;

  // Readies are pure decodes of the state register, never of the valids.
  assign o_a_ready = (r_state == SERVE_A);
  assign o_b_ready = (r_state == SERVE_B);

  // View of the requester being served and of the one waiting.
  assign w_serving   = (r_state == SERVE_A) || (r_state == SERVE_B);
  assign w_cur_id    = (r_state == SERVE_B) ? ID_B : ID_A;
  assign w_cur_valid = (r_state == SERVE_B) ? i_b_valid : i_a_valid;
  assign w_oth_valid = (r_state == SERVE_B) ? i_a_valid : i_b_valid;

  assign w_acc       = w_serving && w_cur_valid;
  assign w_burst_end = (r_burst_cnt == BURST_LAST);

  // Round-robin grant FSM with burst limiting and bubble-free handover.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_last      <= ID_B;          // so A wins the first tie
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_burst_cnt <= '0;
          if (i_a_valid && i_b_valid) begin
            r_state <= serve_state(!r_last);
          end else if (i_a_valid) begin
            r_state <= SERVE_A;
          end else if (i_b_valid) begin
            r_state <= SERVE_B;
          end
        end
        SERVE_A, SERVE_B: begin
          if (w_cur_valid) begin
            if (w_burst_end) begin
              // Burst full: hand over if the other side waits, else restart.
              r_burst_cnt <= '0;
              if (w_oth_valid) begin
                r_state <= serve_state(!w_cur_id);
                r_last  <= w_cur_id;
              end
            end else begin
              r_burst_cnt <= r_burst_cnt + 1'b1;
            end
          end else begin
            // Current requester went quiet: switch directly or fall to idle.
            r_burst_cnt <= '0;
            r_last      <= w_cur_id;
            r_state     <= w_oth_valid ? serve_state(!w_cur_id) : IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_burst_cnt <= '0;
        end
      endcase
    end
  end

  // Both data paths go straight to the mux; select follows the grant.
  assign o_mux_a      = i_a_data;
  assign o_mux_b      = i_b_data;
  assign o_mux_sel    = (r_state == SERVE_B);
  assign o_mux_in_val = w_acc;

  assign w_tag_in.vld = w_acc;
  assign w_tag_in.id  = w_cur_id;

  mux_arb_tag_pipe #(
    .DEPTH (MUX_LATENCY)
  ) u_tag_pipe (
    .i_clk  (i_clk),
    .i_srst (i_reset),
    .i_tag  (w_tag_in),
    .o_tag  (w_tag_out)
  );

  assign o_out_valid = w_tag_out.vld;
  assign o_out_id    = w_tag_out.id;
  assign o_out_data  = i_mux_out;

`ifdef MUX_ARB_STATS_EN
  logic [15:0] r_cnt_a;
  logic [15:0] r_cnt_b;

  // Saturating accepted-beat counters, one per requester.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (w_acc) begin
      if (w_cur_id == ID_A) begin
        if (r_cnt_a != 16'hFFFF) r_cnt_a <= r_cnt_a + 16'd1;
      end else begin
        if (r_cnt_b != 16'hFFFF) r_cnt_b <= r_cnt_b + 16'd1;
      end
    end
  end

  assign o_cnt_a = r_cnt_a;
  assign o_cnt_b = r_cnt_b;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: two instances (MAX_BURST=4 and MAX_BURST=1) share
// one stimulus. A grant/latency model predicts every output each cycle;
// directed literal checks pin the model to hand-computed values.
module tb_mux_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_valid, b_valid;
  logic [31:0] a_data, b_data;

  logic [1:0]  a_ready, b_ready, mux_sel, mux_in_val, out_valid, out_id;
  logic [31:0] mux_a [2];
  logic [31:0] mux_b [2];
  logic [31:0] out_data [2];
  logic [31:0] mx1 [2];
  logic [31:0] mx2 [2];
`ifdef MUX_ARB_STATS_EN
  logic [15:0] cnt_a [2];
  logic [15:0] cnt_b [2];
`endif

  mux_arbiter #(.DW(32), .MAX_BURST(4), .MUX_LATENCY(2)) u_dut0 (
    .i_clk(clk), .i_reset(rst),
    .i_a_valid(a_valid), .i_a_data(a_data), .o_a_ready(a_ready[0]),
    .i_b_valid(b_valid), .i_b_data(b_data), .o_b_ready(b_ready[0]),
    .o_mux_a(mux_a[0]), .o_mux_b(mux_b[0]), .o_mux_sel(mux_sel[0]),
    .o_mux_in_val(mux_in_val[0]), .i_mux_out(mx2[0]),
    .o_out_valid(out_valid[0]), .o_out_id(out_id[0]), .o_out_data(out_data[0])
`ifdef MUX_ARB_STATS_EN
    , .o_cnt_a(cnt_a[0]), .o_cnt_b(cnt_b[0])
`endif
  );

  mux_arbiter #(.DW(32), .MAX_BURST(1), .MUX_LATENCY(2)) u_dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_a_valid(a_valid), .i_a_data(a_data), .o_a_ready(a_ready[1]),
    .i_b_valid(b_valid), .i_b_data(b_data), .o_b_ready(b_ready[1]),
    .o_mux_a(mux_a[1]), .o_mux_b(mux_b[1]), .o_mux_sel(mux_sel[1]),
    .o_mux_in_val(mux_in_val[1]), .i_mux_out(mx2[1]),
    .o_out_valid(out_valid[1]), .o_out_id(out_id[1]), .o_out_data(out_data[1])
`ifdef MUX_ARB_STATS_EN
    , .o_cnt_a(cnt_a[1]), .o_cnt_b(cnt_b[1])
`endif
  );

  // The external 2-cycle registered 2:1 mux, one per DUT, cleared by the same reset.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mx1[k] <= '0;
        mx2[k] <= '0;
      end else begin
        mx1[k] <= mux_sel[k] ? mux_b[k] : mux_a[k];
        mx2[k] <= mx1[k];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 nobody granted, 1 A granted, 2 B granted
  // run:   beats given to the owner in the current burst
  // last:  ID of the requester that most recently gave up the grant
  int          m_owner [2];
  int          m_run [2];
  logic        m_last [2];
  int          m_mb [2];
  logic        pv [2][2];
  logic        pid [2][2];
  logic [31:0] pd [2][2];
  int          m_ca [2];
  int          m_cb [2];

  int          cyc = 0;
  bit          rec_on = 1'b0;
  int          rc0[$], rc1[$];
  logic        qi0[$], qi1[$];
  logic [31:0] qd0[$], qd1[$];

  task automatic model_reset(input int k);
    m_owner[k] = 0;
    m_run[k]   = 0;
    m_last[k]  = 1'b1;
    for (int s = 0; s < 2; s++) begin
      pv[k][s] = 1'b0; pid[k][s] = 1'b0; pd[k][s] = '0;
    end
    m_ca[k] = 0;
    m_cb[k] = 0;
  endtask

  task automatic model_step(input int k);
    int own, other;
    logic acc, id, cv, ov;
    logic [31:0] d;
    own = m_owner[k];
    acc = (own == 1 && a_valid) || (own == 2 && b_valid);
    id  = (own == 2);
    d   = (own == 2) ? b_data : a_data;
    pv[k][1] = pv[k][0]; pid[k][1] = pid[k][0]; pd[k][1] = pd[k][0];
    pv[k][0] = acc;      pid[k][0] = id;        pd[k][0] = d;
    if (acc) begin
      if (id) m_cb[k] = (m_cb[k] < 65535) ? m_cb[k] + 1 : 65535;
      else    m_ca[k] = (m_ca[k] < 65535) ? m_ca[k] + 1 : 65535;
    end
    if (own == 0) begin
      if (a_valid && b_valid) m_owner[k] = m_last[k] ? 1 : 2;
      else if (a_valid)       m_owner[k] = 1;
      else if (b_valid)       m_owner[k] = 2;
    end else begin
      other = 3 - own;
      cv = (own == 1) ? a_valid : b_valid;
      ov = (own == 1) ? b_valid : a_valid;
      if (cv) begin
        m_run[k] = m_run[k] + 1;
        if (m_run[k] == m_mb[k]) begin
          m_run[k] = 0;
          if (ov) begin
            m_owner[k] = other;
            m_last[k]  = (own == 2);
          end
        end
      end else begin
        m_run[k]   = 0;
        m_last[k]  = (own == 2);
        m_owner[k] = ov ? other : 0;
      end
    end
  endtask

  // Compare on the falling edge, advance the model on the rising edge.
  initial begin
    m_mb[0] = 4;
    m_mb[1] = 1;
    model_reset(0);
    model_reset(1);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk1($sformatf("a_ready%0d c%0d", k, cyc), a_ready[k], m_owner[k] == 1);
        chk1($sformatf("b_ready%0d c%0d", k, cyc), b_ready[k], m_owner[k] == 2);
        chk1($sformatf("mux_sel%0d c%0d", k, cyc), mux_sel[k], m_owner[k] == 2);
        chk1($sformatf("in_val%0d c%0d", k, cyc), mux_in_val[k],
             (m_owner[k] == 1 && a_valid) || (m_owner[k] == 2 && b_valid));
        chk32($sformatf("mux_a%0d c%0d", k, cyc), mux_a[k], a_data);
        chk32($sformatf("mux_b%0d c%0d", k, cyc), mux_b[k], b_data);
        chk1($sformatf("out_valid%0d c%0d", k, cyc), out_valid[k], pv[k][1]);
        if (pv[k][1]) begin
          chk1($sformatf("out_id%0d c%0d", k, cyc), out_id[k], pid[k][1]);
          chk32($sformatf("out_data%0d c%0d", k, cyc), out_data[k], pd[k][1]);
        end
`ifdef MUX_ARB_STATS_EN
        chk32($sformatf("cnt_a%0d c%0d", k, cyc), 32'(cnt_a[k]), 32'(m_ca[k]));
        chk32($sformatf("cnt_b%0d c%0d", k, cyc), 32'(cnt_b[k]), 32'(m_cb[k]));
`endif
      end
      if (rec_on && out_valid[0]) begin
        rc0.push_back(cyc); qi0.push_back(out_id[0]); qd0.push_back(out_data[0]);
      end
      if (rec_on && out_valid[1]) begin
        rc1.push_back(cyc); qi1.push_back(out_id[1]); qd1.push_back(out_data[1]);
      end
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (rst) model_reset(k);
        else     model_step(k);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [8:0] ids0;
  logic [5:0] ids1;
  logic [1:0] tbl [20];

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    tick();
    tick();
    @(negedge clk);
    chk1("rst a_ready", a_ready[0], 1'b0);
    chk1("rst b_ready", b_ready[0], 1'b0);
    chk1("rst mux_sel", mux_sel[0], 1'b0);
    chk1("rst in_val", mux_in_val[0], 1'b0);
    chk1("rst out_valid", out_valid[0], 1'b0);
    chk1("rst out_id", out_id[0], 1'b0);

    // Single A beat: grant at cycle 1, result at cycle 3.
    tick(); rst = 1'b0; a_valid = 1'b1; a_data = 32'hAAAA0001;
    @(negedge clk); chk1("s1 c0 a_ready", a_ready[0], 1'b0);
    tick();
    @(negedge clk); chk1("s1 c1 a_ready", a_ready[0], 1'b1);
    chk1("s1 c1 in_val", mux_in_val[0], 1'b1);
    tick(); a_valid = 1'b0;
    tick();
    @(negedge clk);
    chk1("s1 c3 out_valid", out_valid[0], 1'b1);
    chk1("s1 c3 out_id", out_id[0], 1'b0);
    chk32("s1 c3 out_data", out_data[0], 32'hAAAA0001);
    tick(); tick();

    // Both valid continuously: bursts of 4 (dut0) and alternation (dut1).
    do_reset();
    rec_on = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a_valid = 1'b1; b_valid = 1'b1;
      a_data = 32'hA000_0000 + 32'(i);
      b_data = 32'hB000_0000 + 32'(i);
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (4) tick();
    rec_on = 1'b0;
    chk1("s2 dut0 enough beats", qi0.size() >= 9, 1'b1);
    chk1("s5 dut1 enough beats", qi1.size() >= 6, 1'b1);
    if (qi0.size() >= 9) begin
      for (int i = 0; i < 9; i++) ids0[i] = qi0[i];
      chk32("s2 id order", 32'(ids0), 32'h0F0);
      chk32("s2 no bubble A->B", 32'(rc0[4] - rc0[3]), 32'd1);
      chk32("s2 no bubble B->A", 32'(rc0[8] - rc0[7]), 32'd1);
      chk32("s2 first data", qd0[0], 32'hA000_0001);
      chk32("s2 first B data", qd0[4], 32'hB000_0005);
      chk32("s2 second A data", qd0[8], 32'hA000_0009);
    end
    if (qi1.size() >= 6) begin
      for (int i = 0; i < 6; i++) ids1[i] = qi1[i];
      chk32("s5 id alternation", 32'(ids1), 32'h2A);
      chk32("s5 back to back", 32'(rc1[5] - rc1[0]), 32'd5);
      chk32("s5 second data", qd1[1], 32'hB000_0002);
    end

    // A drops mid-burst while B waits: direct switch, next tie to A.
    do_reset();
    a_valid = 1'b1; a_data = 32'h3333_0001; b_data = 32'h3BBB_0001;
    tick(); tick();
    tick(); a_valid = 1'b0; b_valid = 1'b1;
    @(negedge clk); chk1("s3 c3 in_val", mux_in_val[0], 1'b0);
    tick();
    @(negedge clk); chk1("s3 c4 b_ready", b_ready[0], 1'b1);
    chk1("s3 c4 mux_sel", mux_sel[0], 1'b1);
    tick(); b_valid = 1'b0;
    tick(); a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk); chk1("s3 c6 idle a_ready", a_ready[0], 1'b0);
    tick();
    @(negedge clk); chk1("s3 c7 tie to A", a_ready[0], 1'b1);
    chk1("s3 c7 b_ready", b_ready[0], 1'b0);
    tick(); a_valid = 1'b0; b_valid = 1'b0;
    repeat (3) tick();

    // Reset while beats are in flight.
    do_reset();
    repeat (4) tick();
    a_valid = 1'b1; a_data = 32'h4444_0005;
    tick();
    tick(); a_data = 32'h4444_0006; rst = 1'b1;
    @(negedge clk); chk1("s4 c6 in_val", mux_in_val[0], 1'b1);
    tick(); rst = 1'b0; a_valid = 1'b0;
    @(negedge clk); chk1("s4 c7 out_valid", out_valid[0], 1'b0);
    chk1("s4 c7 a_ready", a_ready[0], 1'b0);
    chk1("s4 c7 b_ready", b_ready[0], 1'b0);
    tick();
    @(negedge clk); chk1("s4 c8 out_valid", out_valid[0], 1'b0);
    tick();
    @(negedge clk); chk1("s4 c9 out_valid", out_valid[0], 1'b0);

    // Three A beats then two B beats (counter scenario).
    do_reset();
    a_valid = 1'b1; a_data = 32'h6666_000A;
    tick(); tick(); tick();
    tick(); a_valid = 1'b0; b_valid = 1'b1; b_data = 32'h6666_000B;
    tick(); tick();
    tick(); b_valid = 1'b0;
    tick();
`ifdef MUX_ARB_STATS_EN
    @(negedge clk);
    chk32("s6 cnt_a", 32'(cnt_a[0]), 32'd3);
    chk32("s6 cnt_b", 32'(cnt_b[0]), 32'd2);
    rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk32("s6 cnt_a after reset", 32'(cnt_a[0]), 32'd0);
    chk32("s6 cnt_b after reset", 32'(cnt_b[0]), 32'd0);
`endif

    // Mixed valid patterns, including drops without handshake; model checks.
    tbl = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
            2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00};
    do_reset();
    for (int i = 0; i < 20; i++) begin
      a_valid = tbl[i][0]; b_valid = tbl[i][1];
      a_data = $urandom; b_data = $urandom;
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (4) tick();

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
